// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table predictor.
package bht_pkg;

   // Widest supported counter and PC; cells and requests are sized to these.
   localparam int unsigned BHT_CNT_MAX_W = 4;
   localparam int unsigned BHT_PC_MAX_W  = 64;

   // Resolved-branch update request as it arrives from the resolve stage.
   typedef struct packed {
      logic [BHT_PC_MAX_W-1:0] pc;
      logic                    taken;
   } bht_upd_t;

   // Saturating next count for a w-bit counter held in the low bits of cnt.
   function automatic logic [BHT_CNT_MAX_W-1:0] bht_sat_next(
      input logic [BHT_CNT_MAX_W-1:0] cnt,
      input logic                     up,
      input int unsigned              w
   );
      logic [BHT_CNT_MAX_W-1:0] max_v;
      max_v = BHT_CNT_MAX_W'((1 << w) - 1);
      if (up && (cnt < max_v))
         return cnt + 1'b1;
      else if (!up && (cnt != '0))
         return cnt - 1'b1;
      else
         return cnt;
   endfunction

   // Legal-parameter check used at elaboration time.
   function automatic bit bht_params_ok(
      input int unsigned cnt_w,
      input int unsigned idx_w,
      input int unsigned pc_w,
      input int unsigned init,
      input int unsigned hist_w,
      input int unsigned miss_w
   );
      return (cnt_w >= 1) && (cnt_w <= BHT_CNT_MAX_W) &&
             (idx_w >= 1) && (pc_w >= idx_w + 2) && (pc_w <= BHT_PC_MAX_W) &&
             (init < (1 << cnt_w)) &&
             (hist_w >= 1) && (hist_w <= idx_w) &&
             (miss_w >= 1);
   endfunction

endpackage

// File: rtl/bht_counter_cell.sv
// One CNT_W-bit saturating counter entry of the branch history table.
module bht_counter_cell
   import bht_pkg::*;
#(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned INIT  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   output logic             msb,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0]         r_cnt;
   logic [BHT_CNT_MAX_W-1:0] w_next;
   logic                     w_unused_hi;

   // Next saturating value computed at the package's maximum width.
   always_comb begin
      w_next      = bht_sat_next(BHT_CNT_MAX_W'(r_cnt), up, CNT_W);
      w_unused_hi = ^w_next;
   end

   // Counter state: reset to INIT, otherwise step when enabled.
   always_ff @(posedge clk) begin
      if (!reset)
         r_cnt <= CNT_W'(INIT);
      else if (en)
         r_cnt <= w_next[CNT_W-1:0];
   end

   assign msb = r_cnt[CNT_W-1];
   assign cnt = r_cnt;

endmodule

// File: rtl/bht_predictor.sv
// Branch history table predictor: combinational lookup, one training
// update per cycle, registered mispredict flag and saturating miss count.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_predictor
   import bht_pkg::*;
#(
   parameter int unsigned CNT_W  = 2,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INIT   = 0,
   parameter int unsigned HIST_W = 4,
   parameter int unsigned MISS_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   lookup_pc,
   output logic              prediction,
   input  logic              branch,
   input  logic [PC_W-1:0]   update_pc,
   input  logic              taken,
   output logic              mispredict,
   output logic [MISS_W-1:0] miss_count
);

   localparam int unsigned ENTRIES = 1 << IDX_W;
   localparam bit          P_OK    = bht_params_ok(CNT_W, IDX_W, PC_W, INIT, HIST_W, MISS_W);

   typedef logic [IDX_W-1:0] idx_t;

   if (!P_OK) begin : g_bad_params
      $error("bht_predictor: illegal parameter combination");
   end

   bht_upd_t                      w_upd;
   idx_t                          w_hash;
   idx_t                          w_lu_idx;
   idx_t                          w_upd_idx;
   logic                          w_pre_msb;
   logic [ENTRIES-1:0]            w_msb;
   logic [ENTRIES-1:0]            w_en;
   logic [ENTRIES-1:0][CNT_W-1:0] w_cnt;
   logic                          w_unused;

   logic                          r_mispredict;
   logic [MISS_W-1:0]             r_miss;

`ifdef BHT_GSHARE_EN
   logic [HIST_W-1:0]             r_ghr;

   // Global history: shift in each resolved outcome; update index uses the
   // pre-shift value because w_hash is read in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset)
         r_ghr <= '0;
      else if (branch)
         r_ghr <= HIST_W'({r_ghr, taken});
   end

   assign w_hash = IDX_W'(r_ghr);
`else
   assign w_hash = '0;
`endif

   // Index generation for lookup and update, plus the pre-update MSB.
   always_comb begin
      w_upd.pc    = BHT_PC_MAX_W'(update_pc);
      w_upd.taken = taken;
      w_lu_idx    = lookup_pc[IDX_W+1:2] ^ w_hash;
      w_upd_idx   = w_upd.pc[IDX_W+1:2] ^ w_hash;
      w_pre_msb   = w_msb[w_upd_idx];
      prediction  = w_msb[w_lu_idx];
      w_unused    = ^{lookup_pc, w_upd, w_cnt};
   end

   for (genvar i = 0; i < ENTRIES; i++) begin : g_cell
      assign w_en[i] = branch && (w_upd_idx == IDX_W'(i));

      bht_counter_cell #(
         .CNT_W (CNT_W),
         .INIT  (INIT)
      ) u_cell (
         .clk   (clk),
         .reset (reset),
         .en    (w_en[i]),
         .up    (w_upd.taken),
         .msb   (w_msb[i]),
         .cnt   (w_cnt[i])
      );
   end

   // Registered mispredict pulse and saturating mispredict counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mispredict <= 1'b0;
         r_miss       <= '0;
      end else if (branch) begin
         r_mispredict <= (w_pre_msb != taken);
         if ((w_pre_msb != taken) && (r_miss != '1))
            r_miss <= r_miss + 1'b1;
      end else begin
         r_mispredict <= 1'b0;
      end
   end

   assign mispredict = r_mispredict;
   assign miss_count = r_miss;

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed scenarios plus randomized
// traffic checked against a behavioural table model.
module tb_bht_predictor;

   localparam int unsigned CNT_W  = 2;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned INIT   = 0;
   localparam int unsigned HIST_W = 4;
   localparam int unsigned MISS_W = 16;
   localparam int unsigned NENT   = 1 << IDX_W;
   localparam int unsigned CMAX   = (1 << CNT_W) - 1;
   localparam int unsigned HALF   = 1 << (CNT_W - 1);
   localparam int unsigned MMAX   = (1 << MISS_W) - 1;

   logic              clk;
   logic              reset;
   logic [PC_W-1:0]   lookup_pc;
   logic              prediction;
   logic              branch;
   logic [PC_W-1:0]   update_pc;
   logic              taken;
   logic              mispredict;
   logic [MISS_W-1:0] miss_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   int unsigned m_cnt [NENT];
   int unsigned m_ghr;
   int unsigned m_miss;
   bit          m_mp;

   bht_predictor #(
      .CNT_W  (CNT_W),
      .IDX_W  (IDX_W),
      .PC_W   (PC_W),
      .INIT   (INIT),
      .HIST_W (HIST_W),
      .MISS_W (MISS_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .lookup_pc  (lookup_pc),
      .prediction (prediction),
      .branch     (branch),
      .update_pc  (update_pc),
      .taken      (taken),
      .mispredict (mispredict),
      .miss_count (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned m_idx(input logic [PC_W-1:0] pc);
      int unsigned e;
      e = (int'(pc) / 4) % NENT;
`ifdef BHT_GSHARE_EN
      e = e ^ m_ghr;
`endif
      return e;
   endfunction

   function automatic bit m_pred(input logic [PC_W-1:0] pc);
      return m_cnt[m_idx(pc)] >= HALF;
   endfunction

   // Model reaction to one clock edge given the currently driven inputs.
   function automatic void m_edge();
      int unsigned e;
      bit pre;
      if (!reset) begin
         foreach (m_cnt[k]) m_cnt[k] = INIT;
         m_ghr = 0; m_miss = 0; m_mp = 0;
      end else if (branch) begin
         e   = m_idx(update_pc);
         pre = m_cnt[e] >= HALF;
         m_mp = (pre != taken);
         if (m_mp && m_miss < MMAX) m_miss++;
         if (taken && m_cnt[e] < CMAX) m_cnt[e]++;
         else if (!taken && m_cnt[e] > 0) m_cnt[e]--;
         m_ghr = ((m_ghr << 1) | int'(taken)) % (1 << HIST_W);
      end else begin
         m_mp = 0;
      end
   endfunction

   task automatic clk_edge();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; branch = 1'b0; taken = 1'b1;
      clk_edge();
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         clk_edge();
         for (int p = 0; p < 24; p++) begin
            lookup_pc = PC_W'(p * 4);
            #1;
            n_checks++;
            if (prediction !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_pred pc=%h got=%b exp=0", lookup_pc, prediction);
            end
         end
         n_checks++;
         if (miss_count !== '0 || mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_miss got miss=%0d mp=%b exp 0/0", miss_count, mispredict);
         end
      end
   endtask

   task automatic test_upcount();
      bit exp_p [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      bit exp_m [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      lookup_pc = 32'h10; update_pc = 32'h10; branch = 1'b1; taken = 1'b1;
      for (int k = 0; k < 4; k++) begin
         clk_edge();
         n_checks++;
         if (prediction !== exp_p[k] || mispredict !== exp_m[k]) begin
            n_fail++;
            $display("FAIL upcount step%0d got pred=%b mp=%b exp pred=%b mp=%b",
                     k, prediction, mispredict, exp_p[k], exp_m[k]);
         end
      end
      branch = 1'b0;
      clk_edge();
      n_checks++;
      if (miss_count !== 16'd2 || mispredict !== 1'b0) begin
         n_fail++;
         $display("FAIL upcount_end got miss=%0d mp=%b exp miss=2 mp=0", miss_count, mispredict);
      end
   endtask

   task automatic test_downcount();
      bit exp_p [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      bit exp_m [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      lookup_pc = 32'h10; update_pc = 32'h10; branch = 1'b1; taken = 1'b0;
      for (int k = 0; k < 4; k++) begin
         clk_edge();
         n_checks++;
         if (prediction !== exp_p[k] || mispredict !== exp_m[k]) begin
            n_fail++;
            $display("FAIL downcount step%0d got pred=%b mp=%b exp pred=%b mp=%b",
                     k, prediction, mispredict, exp_p[k], exp_m[k]);
         end
      end
      branch = 1'b0;
      clk_edge();
      n_checks++;
      if (miss_count !== 16'd4) begin
         n_fail++;
         $display("FAIL downcount_end got miss=%0d exp=4", miss_count);
      end
   endtask

   task automatic test_isolation();
      logic [PC_W-1:0] probes [3] = '{32'h10, 32'h14, 32'h50};
      bit              exp_iso [3] = '{1'b1, 1'b0, 1'b1};
      update_pc = 32'h10; branch = 1'b1; taken = 1'b1;
      clk_edge();
      clk_edge();
      branch = 1'b0;
      foreach (probes[k]) begin
         lookup_pc = probes[k];
         #1;
         n_checks++;
         if (prediction !== exp_iso[k] || prediction !== m_pred(probes[k])) begin
            n_fail++;
            $display("FAIL isolation pc=%h got=%b exp=%b", probes[k], prediction, exp_iso[k]);
         end
      end
      // Counter for 0x10 is 2: same-cycle lookup must still see MSB=1.
      lookup_pc = 32'h10; update_pc = 32'h10; branch = 1'b1; taken = 1'b0;
      #1;
      n_checks++;
      if (prediction !== 1'b1) begin
         n_fail++;
         $display("FAIL hazard_same_cycle got=%b exp=1", prediction);
      end
      clk_edge();
      branch = 1'b0;
      #1;
      n_checks++;
      if (prediction !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_next_cycle got=%b exp=0", prediction);
      end
   endtask

   task automatic test_reset_mid();
      lookup_pc = 32'h10; update_pc = 32'h10; branch = 1'b1; taken = 1'b1;
      for (int k = 0; k < 3; k++) clk_edge();
      n_checks++;
      if (prediction !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre got=%b exp=1", prediction);
      end
      reset = 1'b0;
      clk_edge();
      reset = 1'b1; branch = 1'b0;
      #1;
      n_checks++;
      if (prediction !== 1'b0 || miss_count !== '0 || mispredict !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid got pred=%b miss=%0d mp=%b exp 0/0/0",
                  prediction, miss_count, mispredict);
      end
   endtask

`ifdef BHT_GSHARE_EN
   task automatic test_gshare();
      reset = 1'b0; branch = 1'b0;
      clk_edge();
      reset = 1'b1;
      update_pc = 32'h10; branch = 1'b1; taken = 1'b1;
      clk_edge();
      branch = 1'b0;
      lookup_pc = 32'h10;
      #1;
      n_checks++;
      if (prediction !== 1'b0 || m_ghr != 1 || m_cnt[4] != 1) begin
         n_fail++;
         $display("FAIL gshare_idx got=%b exp=0 (ghr=%0d)", prediction, m_ghr);
      end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         reset     = ($urandom_range(63) != 0);
         branch    = $urandom_range(3) != 0;
         taken     = $urandom_range(1) == 1;
         update_pc = PC_W'($urandom_range(2 * NENT + 3) * 4) | PC_W'($urandom_range(3));
         lookup_pc = ($urandom_range(3) == 0) ? update_pc
                                               : PC_W'($urandom_range(2 * NENT + 3) * 4);
         #1;
         n_checks++;
         if (prediction !== m_pred(lookup_pc)) begin
            n_fail++;
            $display("FAIL rand_pred cyc=%0d pc=%h got=%b exp=%b",
                     c, lookup_pc, prediction, m_pred(lookup_pc));
         end
         clk_edge();
         n_checks++;
         if (mispredict !== m_mp || miss_count !== MISS_W'(m_miss)) begin
            n_fail++;
            $display("FAIL rand_post cyc=%0d got mp=%b miss=%0d exp mp=%b miss=%0d",
                     c, mispredict, miss_count, m_mp, m_miss);
         end
      end
      reset = 1'b1; branch = 1'b0;
   endtask

   initial begin
      reset = 1'b1; branch = 1'b0; taken = 1'b0;
      lookup_pc = '0; update_pc = '0;
      foreach (m_cnt[k]) m_cnt[k] = INIT;
      m_ghr = 0; m_miss = 0; m_mp = 0;
      #2;
      test_reset();
`ifdef BHT_GSHARE_EN
      test_gshare();
`else
      test_upcount();
      test_downcount();
      test_isolation();
      test_reset_mid();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
